// File: rtl/ext_pkg.sv
// ext_pkg: shared definitions for the load extend pipeline.
//   - ext_mode_t : 3-bit operation code (EXT_ZB .. EXT_PASS)
//   - ext_al()   : number of low address bits used for lane selection
package ext_pkg;

    typedef enum logic [2:0] {
        EXT_ZB   = 3'd0,
        EXT_SB   = 3'd1,
        EXT_ZH   = 3'd2,
        EXT_SH   = 3'd3,
        EXT_W    = 3'd4,
        EXT_WU   = 3'd5,
        EXT_LUI  = 3'd6,
        EXT_PASS = 3'd7
    } ext_mode_t;

    // Byte-lane address width for a given datapath width (2 at 32, 3 at 64).
    function automatic int ext_al(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/ext_lane_sel.sv
// ext_lane_sel: combinational lane select + zero/sign extension.
//   mode     : operation (ext_mode_t)
//   addr     : low address bits, selects byte/halfword/word lane
//   data     : raw little-endian read word (or LUI immediate in [15:0])
//   res_data : extended result, 0 when res_err is set
//   res_err  : misaligned access for the chosen mode
module ext_lane_sel
    import ext_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int AL     = ext_al(DATA_W)
) (
    input  ext_mode_t          mode,
    input  logic [AL-1:0]      addr,
    input  logic [DATA_W-1:0]  data,
    output logic [DATA_W-1:0]  res_data,
    output logic               res_err
);

    logic [DATA_W-1:0] shift_b;
    logic [DATA_W-1:0] shift_h;
    logic [DATA_W-1:0] shift_w;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       lane_w;
    logic [31:0]       lui_w;
    logic [AL-1:0]     word_idx;

    // Lanes are extracted by shifting the selected lane down to bit 0.
    // The word index is zero at DATA_W=32, so lane 0 is always used there.
    assign word_idx = addr >> 2;
    assign shift_b  = data >> {addr, 3'b000};
    assign shift_h  = data >> {addr[AL-1:1], 4'b0000};
    assign shift_w  = data >> {word_idx, 5'b00000};
    assign lane_b   = shift_b[7:0];
    assign lane_h   = shift_h[15:0];
    assign lane_w   = shift_w[31:0];
    assign lui_w    = {data[15:0], 16'h0000};

    always_comb begin
        res_data = '0;
        res_err  = 1'b0;
        unique case (mode)
            EXT_ZB:   res_data = DATA_W'(lane_b);
            EXT_SB:   res_data = DATA_W'($signed(lane_b));
            EXT_ZH: begin
                res_err  = addr[0];
                res_data = DATA_W'(lane_h);
            end
            EXT_SH: begin
                res_err  = addr[0];
                res_data = DATA_W'($signed(lane_h));
            end
            EXT_W: begin
                res_err  = |addr[1:0];
                res_data = DATA_W'($signed(lane_w));
            end
            EXT_WU: begin
                res_err  = |addr[1:0];
                res_data = DATA_W'(lane_w);
            end
            EXT_LUI:  res_data = DATA_W'($signed(lui_w));
            EXT_PASS: begin
                res_err  = |addr;
                res_data = data;
            end
            default:  res_data = '0;
        endcase
        // A misaligned result never leaks partial data downstream.
        if (res_err) begin
            res_data = '0;
        end
    end

endmodule

// File: rtl/load_ext_pipe.sv
// load_ext_pipe: registered load extender with a 2-entry output buffer.
//   clk, rst_n         : clock, asynchronous active-low reset
//   flush              : synchronous clear of buffered entries (drops same-cycle push)
//   in_valid/in_ready  : request handshake; in_ready depends only on registered count
//   in_mode/addr/data  : extend operation, lane address, raw read word
//   in_tag             : sideband tag carried to the output
//   out_valid/out_ready: result handshake
//   out_data/tag/err   : head entry of the buffer
module load_ext_pipe
    import ext_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int TAG_W  = 5,
    localparam int AL     = ext_al(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [AL-1:0]     in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    logic [DATA_W-1:0] lane_data;
    logic              lane_err;
    logic [1:0]        count_reg;
    logic [1:0]        count_next;
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic              push;
    logic              pop;

    ext_lane_sel #(
        .DATA_W (DATA_W)
    ) u_lane_sel (
        .mode     (ext_mode_t'(in_mode)),
        .addr     (in_addr),
        .data     (in_data),
        .res_data (lane_data),
        .res_err  (lane_err)
    );

    assign in_ready  = (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);
    // flush dominates: neither a push nor a pop takes effect that cycle.
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = 2'd0;
        end else if (push && !pop) begin
            count_next = count_reg + 2'd1;
        end else if (pop && !push) begin
            count_next = count_reg - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (flush) begin
                wr_ptr_reg <= 1'b0;
                rd_ptr_reg <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= ~wr_ptr_reg;
                end
                if (pop) begin
                    rd_ptr_reg <= ~rd_ptr_reg;
                end
            end
        end
    end

    // Buffer entries: each is written only when the write pointer points at it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ent
        logic [DATA_W-1:0] data_reg;
        logic [TAG_W-1:0]  tag_reg;
        logic              err_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_reg <= '0;
                tag_reg  <= '0;
                err_reg  <= 1'b0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                data_reg <= lane_data;
                tag_reg  <= in_tag;
                err_reg  <= lane_err;
            end
        end
    end

    assign out_data = rd_ptr_reg ? g_ent[1].data_reg : g_ent[0].data_reg;
    assign out_tag  = rd_ptr_reg ? g_ent[1].tag_reg  : g_ent[0].tag_reg;
    assign out_err  = rd_ptr_reg ? g_ent[1].err_reg  : g_ent[0].err_reg;

endmodule

// File: tb/tb_load_ext_pipe.sv
module tb_load_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    // 32-bit instance
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_mode = '0;
    logic [1:0]  in_addr = '0;
    logic [31:0] in_data = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_err;

    // 64-bit instance
    logic        v64_in_valid = 1'b0;
    logic        v64_in_ready;
    logic [2:0]  v64_in_addr = '0;
    logic [63:0] v64_in_data = '0;
    logic        v64_out_valid;
    logic [63:0] v64_out_data;
    logic [4:0]  v64_out_tag;
    logic        v64_out_err;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    load_ext_pipe #(.DATA_W(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_addr(in_addr), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_err(out_err)
    );

    load_ext_pipe #(.DATA_W(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(v64_in_valid), .in_ready(v64_in_ready), .in_mode(in_mode),
        .in_addr(v64_in_addr), .in_data(v64_in_data), .in_tag(in_tag),
        .out_valid(v64_out_valid), .out_ready(out_ready), .out_data(v64_out_data),
        .out_tag(v64_out_tag), .out_err(v64_out_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: lane of nbytes starting at byte addr, extended arithmetically.
    function automatic logic [64:0] ref_ext(input int w, input logic [2:0] mode,
                                            input int addr, input logic [63:0] din);
        logic [63:0] wmask;
        logic [63:0] d;
        logic [63:0] lm;
        logic [63:0] v;
        int          nbytes;
        bit          sgn;
        bit          err;
        wmask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        d = din & wmask;
        nbytes = 0;
        sgn = 0;
        err = 0;
        v = 0;
        case (mode)
            3'd0: begin nbytes = 1; sgn = 0; end
            3'd1: begin nbytes = 1; sgn = 1; end
            3'd2: begin nbytes = 2; sgn = 0; end
            3'd3: begin nbytes = 2; sgn = 1; end
            3'd4: begin nbytes = 4; sgn = 1; end
            3'd5: begin nbytes = 4; sgn = 0; end
            default: nbytes = 0;
        endcase
        if (mode == 3'd6) begin
            v = {48'h0, d[15:0]} << 16;
            if (v[31]) v = v | 64'hFFFF_FFFF_0000_0000;
        end else if (mode == 3'd7) begin
            v = d;
            err = (addr != 0);
        end else begin
            err = (addr % nbytes) != 0;
            lm = (64'd1 << (8 * nbytes)) - 64'd1;
            v = (d >> (8 * addr)) & lm;
            if (sgn && v[8 * nbytes - 1]) v = v | ~lm;
        end
        if (err) v = 0;
        return {err, v & wmask};
    endfunction

    typedef struct {
        bit          is64;
        logic [2:0]  mode;
        logic [2:0]  addr;
        logic [63:0] data;
        logic [4:0]  tag;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [4:0]  tag;
    } ent_t;

    vec_t vecs[$];
    ent_t q[$];

    initial begin
        // Reset state
        #12;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_data", 64'(out_data), 64'd0);
        check("reset out_tag", 64'(out_tag), 64'd0);
        check("reset out_err", 64'(out_err), 64'd0);
        check("reset v64 out_valid", 64'(v64_out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        vecs.push_back('{0, 3'd1, 3'd2, 64'h1280_3456, 5'd9,  64'hFFFF_FF80, 1'b0});
        vecs.push_back('{0, 3'd2, 3'd2, 64'h8001_0000, 5'd10, 64'h0000_8001, 1'b0});
        vecs.push_back('{0, 3'd3, 3'd1, 64'h8001_0000, 5'd11, 64'h0, 1'b1});
        vecs.push_back('{0, 3'd6, 3'd0, 64'h0000_ABCD, 5'd12, 64'hABCD_0000, 1'b0});
        vecs.push_back('{1, 3'd6, 3'd0, 64'h0000_ABCD, 5'd13, 64'hFFFF_FFFF_ABCD_0000, 1'b0});
        vecs.push_back('{0, 3'd0, 3'd3, 64'hA1B2_C3D4, 5'd14, 64'h0000_00A1, 1'b0});
        vecs.push_back('{0, 3'd3, 3'd0, 64'h1234_F00F, 5'd15, 64'hFFFF_F00F, 1'b0});
        vecs.push_back('{0, 3'd4, 3'd0, 64'h8765_4321, 5'd16, 64'h8765_4321, 1'b0});
        vecs.push_back('{0, 3'd5, 3'd2, 64'h8765_4321, 5'd17, 64'h0, 1'b1});
        vecs.push_back('{0, 3'd7, 3'd1, 64'hDEAD_BEEF, 5'd18, 64'h0, 1'b1});
        vecs.push_back('{0, 3'd7, 3'd0, 64'hDEAD_BEEF, 5'd19, 64'hDEAD_BEEF, 1'b0});
        vecs.push_back('{0, 3'd6, 3'd3, 64'h0000_7FFF, 5'd20, 64'h7FFF_0000, 1'b0});
        vecs.push_back('{1, 3'd4, 3'd4, 64'h8000_0001_1234_5678, 5'd21, 64'hFFFF_FFFF_8000_0001, 1'b0});
        vecs.push_back('{1, 3'd5, 3'd4, 64'h8000_0001_1234_5678, 5'd22, 64'h0000_0000_8000_0001, 1'b0});
        vecs.push_back('{1, 3'd1, 3'd7, 64'h7F00_0000_0000_0000, 5'd23, 64'h0000_0000_0000_007F, 1'b0});
        vecs.push_back('{1, 3'd2, 3'd6, 64'hABCD_0000_0000_0000, 5'd24, 64'h0000_0000_0000_ABCD, 1'b0});
        vecs.push_back('{1, 3'd4, 3'd2, 64'h8000_0001_1234_5678, 5'd25, 64'h0, 1'b1});
        vecs.push_back('{1, 3'd7, 3'd0, 64'h0123_4567_89AB_CDEF, 5'd26, 64'h0123_4567_89AB_CDEF, 1'b0});

        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_mode = vecs[i].mode;
            in_tag = vecs[i].tag;
            if (vecs[i].is64) begin
                v64_in_addr = vecs[i].addr;
                v64_in_data = vecs[i].data;
                v64_in_valid = 1'b1;
            end else begin
                in_addr = vecs[i].addr[1:0];
                in_data = vecs[i].data[31:0];
                in_valid = 1'b1;
            end
            @(negedge clk);
            in_valid = 1'b0;
            v64_in_valid = 1'b0;
            if (vecs[i].is64) begin
                check($sformatf("vec%0d valid", i), 64'(v64_out_valid), 64'd1);
                check($sformatf("vec%0d data", i), v64_out_data, vecs[i].exp_data);
                check($sformatf("vec%0d err", i), 64'(v64_out_err), 64'(vecs[i].exp_err));
                check($sformatf("vec%0d tag", i), 64'(v64_out_tag), 64'(vecs[i].tag));
            end else begin
                check($sformatf("vec%0d valid", i), 64'(out_valid), 64'd1);
                check($sformatf("vec%0d data", i), 64'(out_data), vecs[i].exp_data);
                check($sformatf("vec%0d err", i), 64'(out_err), 64'(vecs[i].exp_err));
                check($sformatf("vec%0d tag", i), 64'(out_tag), 64'(vecs[i].tag));
            end
            $display("vec %0d mode=%0d addr=%0d tag=%0d done", i, vecs[i].mode, vecs[i].addr, vecs[i].tag);
            @(negedge clk);
        end
        check("drained", 64'(out_valid), 64'd0);

        // Back-pressure: three pushes offered, only two accepted
        out_ready = 1'b0;
        in_mode = 3'd0;
        in_addr = 2'd0;
        in_data = 32'h11;
        for (int t = 1; t <= 3; t++) begin
            in_tag = 5'(t);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp in_ready", 64'(in_ready), 64'd0);
        check("bp head tag", 64'(out_tag), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp in_ready back", 64'(in_ready), 64'd1);
        check("bp second tag", 64'(out_tag), 64'd2);
        @(negedge clk);
        check("bp empty (tag3 dropped)", 64'(out_valid), 64'd0);
        $display("backpressure sequence done");

        // Simultaneous push and pop at count=1
        out_ready = 1'b0;
        in_tag = 5'd0;
        in_valid = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            in_tag = 5'(k);
            @(negedge clk);
            check($sformatf("pp%0d valid", k), 64'(out_valid), 64'd1);
            check($sformatf("pp%0d ready", k), 64'(in_ready), 64'd1);
            check($sformatf("pp%0d tag", k), 64'(out_tag), 64'(k));
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("pp drained", 64'(out_valid), 64'd0);
        $display("push/pop sequence done");

        // Flush with a full buffer and a new request
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_tag = 5'd5;
        @(negedge clk);
        @(negedge clk);
        check("pre-flush full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        in_tag = 5'd7;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("flush push dropped", 64'(out_valid), 64'd0);
        $display("flush sequence done");

        // Randomised traffic against a queue model
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            check("rnd out_valid", 64'(out_valid), 64'(q.size() != 0));
            check("rnd in_ready", 64'(in_ready), 64'(q.size() != 2));
            if (q.size() != 0) begin
                check("rnd data", 64'(out_data), 64'(q[0].data));
                check("rnd err", 64'(out_err), 64'(q[0].err));
                check("rnd tag", 64'(out_tag), 64'(q[0].tag));
            end
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 40) == 0);
            in_mode = 3'($urandom);
            in_addr = 2'($urandom);
            in_data = $urandom;
            in_tag = 5'($urandom);
            @(posedge clk);
            if (flush) begin
                q.delete();
            end else begin
                bit can_push;
                can_push = in_valid && (q.size() < 2);
                if (out_ready && q.size() > 0) void'(q.pop_front());
                if (can_push) begin
                    logic [64:0] r;
                    ent_t e;
                    r = ref_ext(32, in_mode, int'(in_addr), 64'(in_data));
                    e.data = r[31:0];
                    e.err = r[64];
                    e.tag = in_tag;
                    q.push_back(e);
                end
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;
        $display("random traffic done, model depth %0d", q.size());

        // Asynchronous reset mid-stream
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_tag = 5'd3;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", 64'(out_valid), 64'd0);
        check("async rst in_ready", 64'(in_ready), 64'd1);
        check("async rst out_data", 64'(out_data), 64'd0);
        check("async rst out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst empty", 64'(out_valid), 64'd0);
        $display("reset sequence done");

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/load_ext_pipe.md
# load_ext_pipe

Parametrised, registered extend unit for the CPU's memory-writeback path. It replaces fixed 16-to-32 zero-extension with a moded extender. The extender selects a byte, halfword or word lane from a DATA_W-wide read word, zero- or sign-extends it, or builds a LUI-style upper immediate. Results pass through a 2-entry output buffer with valid/ready handshakes, so the writeback stage can stall without losing data.

## Interface
- DATA_W, 32: datapath width; legal values are 32 or 64.
- TAG_W, 5: width of the sideband tag (destination register number).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active low.
- flush  in  1  synchronous clear of all buffered entries.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request this cycle.
- in_mode  in  3  operation: 0 ZB, 1 SB, 2 ZH, 3 SH, 4 W (sign), 5 WU (zero), 6 LUI, 7 PASS.
- in_addr  in  AL  low address bits used for lane selection; AL = log2(DATA_W/8).
- in_data  in  DATA_W  raw read word (little-endian lanes), or the immediate in bits [15:0] for LUI.
- in_tag  in  TAG_W  carried unchanged to the output.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  extended result.
- out_tag  out  TAG_W  tag of the result.
- out_err  out  1  misaligned access; out_data is 0 when set.

## Operation
- Lane selection:
  - Byte lane = in_addr.
  - Halfword lane = in_addr[AL-1:1].
  - Word lane = in_addr[AL-1:2] (64-bit only; always lane 0 at 32).
- Mode results:
  - ZB/ZH/WU: zero-extend the selected lane to DATA_W.
  - SB/SH/W: replicate the lane MSB into the upper bits.
  - LUI: {in_data[15:0], 16'h0}, sign-extended from bit 31 to DATA_W.
  - PASS: in_data unchanged.
- Alignment errors:
  - ZH/SH require in_addr[0]=0.
  - W/WU require in_addr[1:0]=0.
  - PASS requires in_addr=0.
  - ZB/SB/LUI never error.
  - On error: out_err=1, out_data=0, tag still delivered.
- At DATA_W=32, W, WU and PASS produce identical data.
- Buffer:
  - 2-entry FIFO of {data, err, tag}, with a 2-bit count in 0..2.
  - A push occurs on in_valid&&in_ready.
  - A pop occurs on out_valid&&out_ready.
  - Extension is computed combinationally on the input side and stored in the entry.
- in_ready = (count != 2). It is a function of registered state only; there is no combinational path from out_ready.
- out_valid = (count != 0). out_data, out_tag and out_err show the head entry.
- Push and pop in the same cycle: count is unchanged and order is preserved.
- flush:
  - count goes to 0 on the next edge. Any push in the same cycle is dropped.
  - Pointers reset to 0.
  - flush has priority over push and pop.

## Timing
- Reset (rst_n=0, asynchronous):
  - count=0 and pointers=0.
  - out_valid=0, in_ready=1.
  - out_data=0, out_tag=0, out_err=0; entry storage is cleared.
- Latency: a request accepted at edge N is visible at the output after edge N (out_valid=1 in cycle N+1).
- Throughput is one result per cycle while out_ready=1.
- With out_ready=0, two results are accepted; in_ready falls in the cycle after the second push.
- out_data, out_tag and out_err hold stable while out_valid=1 and out_ready=0.
- Reset mid-operation discards all entries; no partial result is emitted.
- Pointers wrap modulo 2.

## Structure
- Shared package ext_pkg holds:
  - Mode constants EXT_ZB…EXT_PASS.
  - The 3-bit mode typedef.
  - The function computing AL from DATA_W.
- Natural sub-module: ext_lane_sel. It is combinational and computes {data, err} from mode, addr and data.
- The top level holds the 2-entry buffer and the handshake logic.

## Test plan
- DATA_W=32, SB, addr=2, data=32'h1280_3456, out_ready=1 -> next cycle out_data=32'hFFFF_FF80, err=0, tag unchanged.
- ZH addr=2 data=32'h8001_0000 -> 32'h0000_8001; SH addr=1 -> err=1, out_data=0.
- LUI data=32'h0000_ABCD:
  - DATA_W=32 -> 32'hABCD_0000.
  - DATA_W=64 -> 64'hFFFF_FFFF_ABCD_0000.
- Back-pressure: out_ready=0 and push tags 1,2,3.
  - Expect in_ready=0 after 2 pushes and tag 3 not accepted.
  - Then release out_ready and expect outputs tags 1,2 in order, with in_ready back to 1.
- Simultaneous push and pop at count=1 for 10 cycles -> count stays 1 and tags emerge in order.
- Reset and flush:
  - flush with count=2 and in_valid=1 -> out_valid=0 next cycle and the new request dropped.
  - rst_n low mid-stream -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
